// File: rtl/mem_pkg.sv
// Shared definitions for the data memory load/store unit: funct3 size codes,
// FSM encoding and the access-width helper.
package mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bytes touched by an access; 0 marks an illegal size code.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: size_bytes = 3'd1;
      SZ_H, SZ_HU: size_bytes = 3'd2;
      SZ_W:        size_bytes = 3'd4;
      default:     size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with four byte lanes starting at a base index. No reset:
// contents survive rst. Lane indices wrap modulo the array size; the caller
// only enables lanes for in-range accesses.
module mem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] base,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // Per-lane byte writes, little-endian from base.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[base + IDX_W'(i)] <= wdata[8*i +: 8];
    end
  end

  // Combinational four-byte read from base.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[base + IDX_W'(i)];
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a byte array: sized RISC-V accesses with a
// req/ready/valid handshake, configurable wait latency, range and alignment checks.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              fault_o
);

  localparam int   IDX_W = $clog2(DEPTH_BYTES);
  localparam logic LAT0  = (LATENCY == 0);

  state_t            state;
  logic [2:0]        cnt;
  logic              lat_we;
  logic [2:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              cur_we;
  logic [2:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic              go_resp;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   last_byte;
  logic              fault, misal, ok;
  logic [3:0]        be;
  logic [31:0]       rd, ext;

  // With zero latency the access completes on the accept edge, so the checks
  // and the array see the live inputs in IDLE and the latched request otherwise.
  always_comb begin
    cur_we    = (state == IDLE) ? we_i    : lat_we;
    cur_size  = (state == IDLE) ? size_i  : lat_size;
    cur_addr  = (state == IDLE) ? addr_i  : lat_addr;
    cur_wdata = (state == IDLE) ? wdata_i : lat_wdata;
  end

  // Range/size/alignment checks, lane enables and load extension for the access.
  always_comb begin
    go_resp   = (LAT0 && state == IDLE && req_i) || (state == WAIT && cnt == '0);
    nbytes    = size_bytes(cur_size);
    last_byte = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    fault     = (nbytes == 3'd0) || (last_byte >= (ADDR_W+1)'(DEPTH_BYTES));
    misal     = ((cur_size == SZ_H || cur_size == SZ_HU) && cur_addr[0]) ||
                ((cur_size == SZ_W) && cur_addr[1:0] != 2'b00);
    ok        = !fault && !misal;
    be        = '0;
    if (go_resp && cur_we && ok && !rst) begin
      case (nbytes)
        3'd1:    be = 4'b0001;
        3'd2:    be = 4'b0011;
        3'd4:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
    ext = '0;
    case (cur_size)
      SZ_B:    ext = {{24{rd[7]}}, rd[7:0]};
      SZ_H:    ext = {{16{rd[15]}}, rd[15:0]};
      SZ_W:    ext = rd;
      SZ_BU:   ext = {24'd0, rd[7:0]};
      SZ_HU:   ext = {16'd0, rd[15:0]};
      default: ext = '0;
    endcase
  end

  mem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .be    (be),
    .base  (cur_addr[IDX_W-1:0]),
    .wdata (cur_wdata),
    .rdata (rd)
  );

  // Handshake FSM with registered outputs; response fields captured on RESP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      rdata_o    <= '0;
      misalign_o <= 1'b0;
      fault_o    <= 1'b0;
      lat_we     <= 1'b0;
      lat_size   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (req_i) begin
          lat_we    <= we_i;
          lat_size  <= size_i;
          lat_addr  <= addr_i;
          lat_wdata <= wdata_i;
          ready_o   <= 1'b0;
          if (LAT0) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= 3'(LATENCY - 1);
          end
        end
        WAIT: if (cnt == '0) state <= RESP;
              else           cnt   <= cnt - 3'd1;
        RESP: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        valid_o    <= 1'b1;
        rdata_o    <= (ok && !cur_we) ? ext : 32'd0;
        misalign_o <= misal;
        fault_o    <= fault;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: three instances (LATENCY 1, 2, 0) sharing clock,
// reset and request fields, each with its own req. Responses are scored
// against a per-instance queue of expected results.
module tb_data_mem_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [3];
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic        rdy [3];
  logic        vld [3];
  logic        mis [3];
  logic        flt [3];
  logic [31:0] rd  [3];

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_BYTES(1024), .LATENCY(1), .ADDR_W(32)) u_l1 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .ready_o(rdy[0]), .valid_o(vld[0]), .rdata_o(rd[0]),
    .misalign_o(mis[0]), .fault_o(flt[0]));
  data_mem_lsu #(.DEPTH_BYTES(1024), .LATENCY(2), .ADDR_W(32)) u_l2 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .ready_o(rdy[1]), .valid_o(vld[1]), .rdata_o(rd[1]),
    .misalign_o(mis[1]), .fault_o(flt[1]));
  data_mem_lsu #(.DEPTH_BYTES(1024), .LATENCY(0), .ADDR_W(32)) u_l0 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .ready_o(rdy[2]), .valid_o(vld[2]), .rdata_o(rd[2]),
    .misalign_o(mis[2]), .fault_o(flt[2]));

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    string       name;
  } exp_t;

  typedef struct {
    int          k;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    string       name;
  } vec_t;

  exp_t sbq [3][$];
  vec_t tbl [$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b0;
  exp_t mon_e;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input string nm, input logic w, input logic [2:0] s,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] r, input logic m, input logic f);
    vec_t v;
    v.k = k; v.name = nm; v.we = w; v.size = s; v.addr = a; v.wdata = wd;
    v.rdata = r; v.mis = m; v.flt = f;
    return v;
  endfunction

  // Scoreboard: pop and compare on every response pulse.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      for (int k = 0; k < 3; k++) begin
        if (vld[k]) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("unexpected valid dut%0d", k), 32'd1, 32'd0);
          end else begin
            mon_e = sbq[k].pop_front();
            check({mon_e.name, " rdata"},    rd[k],         mon_e.rdata);
            check({mon_e.name, " misalign"}, 32'(mis[k]),   32'(mon_e.mis));
            check({mon_e.name, " fault"},    32'(flt[k]),   32'(mon_e.flt));
          end
        end
      end
    end
  end

  // One transaction: wait for ready, drive for one cycle, expect the pulse
  // LATENCY+1 cycles after the accept and for exactly one cycle.
  task automatic do_op(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[v.k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({v.name, " ready before issue"}, 32'(rdy[v.k]), 32'd1);
    we = v.we; size = v.size; addr = v.addr; wdata = v.wdata;
    req[v.k] = 1'b1;
    sbq[v.k].push_back('{v.rdata, v.mis, v.flt, v.name});
    n = 0;
    do begin
      @(negedge clk);
      req[v.k] = 1'b0;
      n++;
    end while (!vld[v.k] && n < 20);
    check({v.name, " latency"}, 32'(n), 32'(lat_of(v.k) + 1));
    @(negedge clk);
    check({v.name, " single pulse"}, 32'(vld[v.k]), 32'd0);
  endtask

  // req held for six cycles: accepts every LATENCY+2 cycles, pulse LATENCY+1 after each.
  task automatic hs(input int k);
    int   L, hi;
    int   acc [$];
    int   val [$];
    int   ea  [$];
    logic rh  [12];
    L = lat_of(k);
    sb_en = 1'b0;
    we = 1'b0; size = SZ_W; addr = 32'h10; wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req[k] = (c < 6);
      rh[c] = rdy[k];
      if (rdy[k] && req[k]) acc.push_back(c);
      if (vld[k]) val.push_back(c);
    end
    req[k] = 1'b0;
    for (int a = 0; a < 6; a += L + 2) ea.push_back(a);
    check($sformatf("hs dut%0d accept count", k), 32'(acc.size()), 32'(ea.size()));
    check($sformatf("hs dut%0d valid count", k),  32'(val.size()), 32'(ea.size()));
    hi = 0;
    foreach (ea[i]) begin
      if (i < acc.size()) check($sformatf("hs dut%0d accept %0d cycle", k, i), 32'(acc[i]), 32'(ea[i]));
      if (i < val.size()) check($sformatf("hs dut%0d valid %0d cycle", k, i),  32'(val[i]), 32'(ea[i] + L + 1));
      for (int c = ea[i] + 1; c <= ea[i] + L + 1; c++) if (rh[c]) hi++;
    end
    check($sformatf("hs dut%0d ready low while busy", k), 32'(hi), 32'd0);
    sb_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    we = 1'b0; size = SZ_W; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset dut%0d ready", k),    32'(rdy[k]), 32'd1);
      check($sformatf("reset dut%0d valid", k),    32'(vld[k]), 32'd0);
      check($sformatf("reset dut%0d rdata", k),    rd[k],       32'd0);
      check($sformatf("reset dut%0d misalign", k), 32'(mis[k]), 32'd0);
      check($sformatf("reset dut%0d fault", k),    32'(flt[k]), 32'd0);
    end
    rst = 1'b0;
    sb_en = 1'b1;

    tbl.push_back(mk(0, "SW 10",      1, SZ_W,   32'h10,  32'hDEADBEEF, 32'h0,        0, 0));
    tbl.push_back(mk(0, "LW 10",      0, SZ_W,   32'h10,  32'h0,        32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, "LB 10",      0, SZ_B,   32'h10,  32'h0,        32'hFFFFFFEF, 0, 0));
    tbl.push_back(mk(0, "LBU 10",     0, SZ_BU,  32'h10,  32'h0,        32'h000000EF, 0, 0));
    tbl.push_back(mk(0, "LH 12",      0, SZ_H,   32'h12,  32'h0,        32'hFFFFDEAD, 0, 0));
    tbl.push_back(mk(0, "LHU 12",     0, SZ_HU,  32'h12,  32'h0,        32'h0000DEAD, 0, 0));
    tbl.push_back(mk(0, "SB 11",      1, SZ_B,   32'h11,  32'h12345677, 32'h0,        0, 0));
    tbl.push_back(mk(0, "LW 10 post SB", 0, SZ_W, 32'h10, 32'h0,        32'hDEAD77EF, 0, 0));
    tbl.push_back(mk(0, "LW 13",      0, SZ_W,   32'h13,  32'h0,        32'h0,        1, 0));
    tbl.push_back(mk(0, "SH 11",      1, SZ_H,   32'h11,  32'hAAAA,     32'h0,        1, 0));
    tbl.push_back(mk(0, "LW 10 post SH", 0, SZ_W, 32'h10, 32'h0,        32'hDEAD77EF, 0, 0));
    tbl.push_back(mk(0, "SW 3FC",     1, SZ_W,   32'h3FC, 32'hCAFEF00D, 32'h0,        0, 0));
    tbl.push_back(mk(0, "LW 3FC",     0, SZ_W,   32'h3FC, 32'h0,        32'hCAFEF00D, 0, 0));
    tbl.push_back(mk(0, "LH 3FE",     0, SZ_H,   32'h3FE, 32'h0,        32'hFFFFCAFE, 0, 0));
    tbl.push_back(mk(0, "LW 3FE",     0, SZ_W,   32'h3FE, 32'h0,        32'h0,        1, 1));
    tbl.push_back(mk(0, "LW 400",     0, SZ_W,   32'h400, 32'h0,        32'h0,        0, 1));
    tbl.push_back(mk(0, "SH 3FF",     1, SZ_H,   32'h3FF, 32'h1111,     32'h0,        1, 1));
    tbl.push_back(mk(0, "S size011",  1, 3'b011, 32'h10,  32'h0,        32'h0,        0, 1));
    tbl.push_back(mk(0, "L size111",  0, 3'b111, 32'h10,  32'h0,        32'h0,        0, 1));
    tbl.push_back(mk(0, "LW 10 post bad", 0, SZ_W, 32'h10, 32'h0,       32'hDEAD77EF, 0, 0));
    tbl.push_back(mk(0, "SB 3FF",     1, SZ_B,   32'h3FF, 32'h0000005A, 32'h0,        0, 0));
    tbl.push_back(mk(0, "LB 3FF",     0, SZ_B,   32'h3FF, 32'h0,        32'h0000005A, 0, 0));
    tbl.push_back(mk(0, "LH 3FE post SB", 0, SZ_H, 32'h3FE, 32'h0,      32'h00005AFE, 0, 0));
    tbl.push_back(mk(0, "SW 20",      1, SZ_W,   32'h20,  32'h55667788, 32'h0,        0, 0));
    tbl.push_back(mk(2, "L0 SW 40",   1, SZ_W,   32'h40,  32'h89ABCDEF, 32'h0,        0, 0));
    tbl.push_back(mk(2, "L0 LH 42",   0, SZ_H,   32'h42,  32'h0,        32'hFFFF89AB, 0, 0));
    tbl.push_back(mk(2, "L0 LB 43",   0, SZ_B,   32'h43,  32'h0,        32'hFFFFFF89, 0, 0));
    tbl.push_back(mk(2, "L0 LW 41",   0, SZ_W,   32'h41,  32'h0,        32'h0,        1, 0));
    tbl.push_back(mk(1, "L2 SH 40",   1, SZ_H,   32'h40,  32'h0000BEEF, 32'h0,        0, 0));
    tbl.push_back(mk(1, "L2 LHU 40",  0, SZ_HU,  32'h40,  32'h0,        32'h0000BEEF, 0, 0));
    tbl.push_back(mk(1, "L2 LW 400",  0, SZ_W,   32'h400, 32'h0,        32'h0,        0, 1));
    foreach (tbl[i]) do_op(tbl[i]);

    // Reset during WAIT of a store: abort, no pulse, old contents kept.
    @(negedge clk);
    check("abort ready before issue", 32'(rdy[0]), 32'd1);
    we = 1'b1; size = SZ_W; addr = 32'h20; wdata = 32'h11223344; req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    check("abort accepted", 32'(rdy[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("abort ready in reset", 32'(rdy[0]), 32'd1);
    check("abort valid in reset", 32'(vld[0]), 32'd0);
    check("abort rdata in reset", rd[0],       32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort no valid %0d", c), 32'(vld[0]), 32'd0);
    end
    do_op(mk(0, "LW 20 after abort", 0, SZ_W, 32'h20, 32'h0, 32'h55667788, 0, 0));

    hs(1);
    hs(2);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("dut%0d responses outstanding", k), 32'(sbq[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
